serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor computing diff = a - b, LSB first, one bit per clock, through a full-subtractor cell and a borrow flip-flop.
- Complements the combinational full adder in the arithmetic library. It is the subtract direction of the same carry/sum datapath, in serial form for area-constrained datapaths.
- Sits behind a simple start/busy/done handshake driven by a controller.

Parameters:
- WIDTH, 8, operand and result width in bits (must be >= 2).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to begin a subtraction; sampled on clk rising edge.
- a  input  WIDTH  minuend; captured only on the edge that accepts start.
- b  input  WIDTH  subtrahend; captured only on the edge that accepts start.
- busy  output  1  high while bits are being processed (state SHIFT).
- done  output  1  single-cycle pulse when the result is valid.
- diff  output  WIDTH  result a - b, modulo 2^WIDTH.
- borrow  output  1  unsigned borrow out: 1 iff a < b (unsigned).
- ovf  output  1  signed overflow of a - b (two's complement).

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; busy=0, done=0, diff=0, borrow=0, ovf=0; internal shift registers, borrow flop and bit counter cleared.
- FSM states are IDLE, SHIFT, DONE.
- IDLE: start=1 at edge E0 is accepted. On that edge:
  - latch a and b into shift registers;
  - latch a[WIDTH-1] and b[WIDTH-1] for ovf;
  - clear the borrow flop;
  - set counter=0;
  - go to SHIFT.
- SHIFT, edges E1..E_WIDTH:
  - the full-subtractor cell takes LSB(a_sr), LSB(b_sr) and borrow_q, producing d and bout;
  - d shifts into the MSB of the result register, a_sr and b_sr shift right, borrow_q <= bout, counter increments.
  - On edge E_WIDTH (counter == WIDTH-1), the state goes to DONE and the final d and bout are included in the outputs.
- Cell equations:
  - d = x ^ y ^ bin
  - bout = (~x & y) | (~(x ^ y) & bin)
- Output update: diff, borrow and ovf are written only on the edge entering DONE, and hold their value at all other times, including during the next operation.
  - borrow = final bout.
  - ovf = (a_msb != b_msb) && (diff[WIDTH-1] != a_msb).
- DONE: done=1 and busy=0 for exactly one cycle.
  - Next edge: if start=1, it is accepted as in IDLE (back-to-back; go directly to SHIFT). Otherwise go to IDLE.
- Latency: start high in cycle C gives done high in cycle C+WIDTH+1. Throughput is one operation per WIDTH+1 cycles.
- start while in SHIFT: ignored; operands are not re-captured and the running operation is unaffected.
- a/b changes after acceptance: no effect on the result.
- Reset mid-operation: the operation is aborted, outputs return to reset values immediately, and no done pulse is produced. The first start after rst_n deasserts is accepted normally.
- done and busy are never high simultaneously.

Decomposition:
- Shared package arith_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2;
  - the counter width rule, clog2(WIDTH), shared with future serial arithmetic blocks.
- One sub-module: full_subtractor (inputs x, y, bin; outputs d, bout), purely combinational. It is instantiated once inside serial_subtractor.

Test Plan:
- WIDTH=8; a=0x05, b=0x03, start 1 cycle -> busy for 8 cycles, then done pulse with diff=0x02, borrow=0, ovf=0; done at start cycle+9.
- a=0x03, b=0x05 -> diff=0xFE, borrow=1, ovf=0. Then a=0x80, b=0x01 -> diff=0x7F, borrow=0, ovf=1. Then a=0x7F, b=0xFF -> diff=0x80, borrow=1, ovf=1.
- a=0x10, b=0x01 accepted; pulse start again with a=0xFF, b=0x00 and change a/b during SHIFT -> single done, diff=0x0F, borrow=0; no second operation starts.
- Back-to-back: start held high through the DONE cycle with the second operands a=0x00, b=0x01 -> first done, then second done 9 cycles later with diff=0xFF, borrow=1, ovf=0.
- Assert rst_n=0 at SHIFT cycle 4 -> busy, done, diff, borrow, ovf = 0 immediately, no done pulse; the next op a=0x0A, b=0x0A gives diff=0x00, borrow=0, ovf=0.
- Exhaustive WIDTH=4 sweep of all 256 (a,b) pairs -> diff, borrow and ovf match the reference model (a-b) mod 16, a<b, and the signed-overflow rule.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared arithmetic-library definitions: serial FSM state encoding
// and the bit-counter width rule used by serial arithmetic blocks.
package arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = x - y - bin, bout = borrow out.
// Ports: x, y, bin in; d, bout out. Purely combinational.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock, start/busy/done.
// Ports: clk, rst_n, start, a, b in; busy, done, diff, borrow, ovf out.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf
);

  localparam int CW = cnt_w(WIDTH);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] r_sr;
  logic [CW-1:0]    cnt_q;
  logic             bq;
  logic             amsb;
  logic             bmsb;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             ovf_q;
  logic             d;
  logic             bout;
  logic             acc;
  logic             last;

  full_subtractor u_fs (
    .x    (a_sr[0]),
    .y    (b_sr[0]),
    .bin  (bq),
    .d    (d),
    .bout (bout)
  );

  // start is only honoured outside SHIFT (IDLE or back-to-back DONE)
  assign acc  = start && (state_q != ST_SHIFT);
  assign last = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_SHIFT;
      ST_SHIFT: if (last)  state_d = ST_DONE;
      ST_DONE:  state_d = start ? ST_SHIFT : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr     <= '0;
      b_sr     <= '0;
      r_sr     <= '0;
      cnt_q    <= '0;
      bq       <= 1'b0;
      amsb     <= 1'b0;
      bmsb     <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (acc) begin
      a_sr  <= a;
      b_sr  <= b;
      amsb  <= a[WIDTH-1];
      bmsb  <= b[WIDTH-1];
      bq    <= 1'b0;
      cnt_q <= '0;
    end else if (state_q == ST_SHIFT) begin
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      r_sr  <= {d, r_sr[WIDTH-1:1]};
      bq    <= bout;
      cnt_q <= cnt_q + 1'b1;
      // last bit: publish result; d is the result MSB
      if (last) begin
        diff_q   <= {d, r_sr[WIDTH-1:1]};
        borrow_q <= bout;
        ovf_q    <= (amsb ^ bmsb) & (d ^ amsb);
      end
    end
  end

  assign busy   = (state_q == ST_SHIFT);
  assign done   = (state_q == ST_DONE);
  assign diff   = diff_q;
  assign borrow = borrow_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH 8 and 4).
// Checks latency, handshake, results, reset abort, 4-bit sweep.
module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       borrow;
  logic       ovf;

  logic       start4;
  logic [3:0] a4;
  logic [3:0] b4;
  logic       busy4;
  logic       done4;
  logic [3:0] diff4;
  logic       borrow4;
  logic       ovf4;

  int n_asrt = 0;
  int n_fail = 0;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow),
    .ovf    (ovf)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start4),
    .a      (a4),
    .b      (b4),
    .busy   (busy4),
    .done   (done4),
    .diff   (diff4),
    .borrow (borrow4),
    .ovf    (ovf4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // From the current negedge, count samples until done (bounded).
  task automatic wait_done(output int n, output int bc);
    n  = 0;
    bc = 0;
    while (done !== 1'b1 && n < 20) begin
      if (busy === 1'b1) bc++;
      if (done === 1'b1 && busy === 1'b1) bc = 99;
      n++;
      @(negedge clk);
    end
  endtask

  task automatic op8(input logic [7:0] ia, input logic [7:0] ib,
                     input logic [7:0] ed, input logic eb,
                     input logic eo, input string tag);
    int n;
    int bc;
    @(negedge clk);
    a = ia; b = ib; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n, bc);
    check({tag, " lat"}, n, 8);
    check({tag, " busy"}, bc, 8);
    check({tag, " hs"}, {done, busy}, 2'b10);
    check({tag, " diff"}, diff, ed);
    check({tag, " borrow"}, borrow, eb);
    check({tag, " ovf"}, ovf, eo);
  endtask

  task automatic op4(input logic [3:0] ia, input logic [3:0] ib);
    int n;
    int sa;
    int sb;
    int sd;
    logic [3:0] ed;
    logic eb;
    logic eo;
    string tag;
    ed = ia - ib;
    eb = (ia < ib);
    sa = (ia >= 8) ? int'(ia) - 16 : int'(ia);
    sb = (ib >= 8) ? int'(ib) - 16 : int'(ib);
    sd = sa - sb;
    eo = (sd > 7) || (sd < -8);
    tag = $sformatf("w4 %0h-%0h", ia, ib);
    @(negedge clk);
    a4 = ia; b4 = ib; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    n = 0;
    while (done4 !== 1'b1 && n < 10) begin
      n++;
      @(negedge clk);
    end
    check({tag, " lat"}, n, 4);
    check({tag, " d"}, diff4, ed);
    check({tag, " b"}, borrow4, eb);
    check({tag, " o"}, ovf4, eo);
  endtask

  initial begin
    int n;
    int bc;
    int seen;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    start4 = 1'b0; a4 = '0; b4 = '0;
    #12;
    check("rst out", {busy, done, diff, borrow, ovf}, 12'h0);
    @(negedge clk);
    rst_n = 1'b1;

    op8(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, "05-03");
    op8(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, "03-05");
    op8(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, "80-01");
    op8(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, "7F-FF");

    // start pulse and operand churn during SHIFT are ignored
    @(negedge clk);
    a = 8'h10; b = 8'h01; start = 1'b1;
    @(negedge clk);
    a = 8'hFF; b = 8'h00; start = 1'b1;
    @(negedge clk);
    a = 8'hAA; b = 8'h55; start = 1'b0;
    wait_done(n, bc);
    check("ign lat", n, 7);
    check("ign diff", diff, 8'h0F);
    check("ign borrow", borrow, 1'b0);
    check("ign ovf", ovf, 1'b0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (busy || done) seen++;
    end
    check("ign no 2nd op", seen, 0);

    // back-to-back: start held through DONE with new operands
    @(negedge clk);
    a = 8'h20; b = 8'h10; start = 1'b1;
    @(negedge clk);
    wait_done(n, bc);
    check("b2b 1st lat", n, 8);
    check("b2b 1st diff", diff, 8'h10);
    a = 8'h00; b = 8'h01;
    @(negedge clk);
    check("b2b accepted", {busy, done}, 2'b10);
    start = 1'b0;
    wait_done(n, bc);
    check("b2b 2nd lat", n, 8);
    check("b2b 2nd diff", diff, 8'hFF);
    check("b2b 2nd borrow", borrow, 1'b1);
    check("b2b 2nd ovf", ovf, 1'b0);

    // reset during SHIFT aborts with no done pulse
    @(negedge clk);
    a = 8'h33; b = 8'h11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid rst out", {busy, done, diff, borrow, ovf}, 12'h0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("mid no done", seen, 0);
    op8(8'h0A, 8'h0A, 8'h00, 1'b0, 1'b0, "0A-0A");

    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        op4(4'(i), 4'(j));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
